// File: rtl/floodit_pkg.sv
// Shared constants and types for the flood-it board checker.
package floodit_pkg;

    // Default board geometry and colour encoding
    localparam int unsigned MAX_SIZE = 26;
    localparam int unsigned COLOR_W  = 3;

    // Fixed interface widths
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned MOVES_W = 8;
    localparam int unsigned COUNT_W = 10;

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    // Colour codes
    localparam logic [COLOR_W-1:0] COLOR_RED    = 3'd0;
    localparam logic [COLOR_W-1:0] COLOR_GREEN  = 3'd1;
    localparam logic [COLOR_W-1:0] COLOR_BLUE   = 3'd2;
    localparam logic [COLOR_W-1:0] COLOR_YELLOW = 3'd3;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StFinish
    } checker_state_e;

    // Limit a requested board edge to the largest supported one
    function automatic logic [ADDR_W-1:0] clamp_size(input logic [ADDR_W-1:0] size,
                                                     input int unsigned      max_size);
        if (32'(size) > max_size) begin
            return ADDR_W'(max_size);
        end
        return size;
    endfunction

endpackage

// File: rtl/cell_scan_counter.sv
// Row-major cell address generator: column wraps at size-1 and bumps the row.
module cell_scan_counter #(
    parameter int unsigned AddrW = floodit_pkg::ADDR_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             advance_i,
    input  logic [AddrW-1:0] size_i,
    output logic [AddrW-1:0] row_o,
    output logic [AddrW-1:0] col_o,
    output logic             last_o
);

    localparam logic [AddrW-1:0] One = {{(AddrW-1){1'b0}}, 1'b1};

    logic [AddrW-1:0] row_q;
    logic [AddrW-1:0] col_q;
    logic [AddrW-1:0] max_idx;

    assign max_idx = size_i - One;
    assign last_o  = (row_q == max_idx) && (col_q == max_idx);
    assign row_o   = row_q;
    assign col_o   = col_q;

    // Address register: clear restarts at (0,0), advance steps in row-major order
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clear_i) begin
            row_q <= '0;
            col_q <= '0;
        end else if (advance_i) begin
            if (col_q == max_idx) begin
                col_q <= '0;
                row_q <= row_q + One;
            end else begin
                col_q <= col_q + One;
            end
        end
    end

endmodule

// File: rtl/board_checker.sv
// Scans a square colour board and reports win/lose plus the count of cells
// matching cell (0,0). Define CHECKER_PROGRESS_EN for full scans with a live
// FLOOD_COUNT; otherwise FLOOD_COUNT is 0 and the scan stops at the first
// mismatching cell.
module board_checker #(
    parameter int unsigned MAX_SIZE = floodit_pkg::MAX_SIZE,
    parameter int unsigned COLOR_W  = floodit_pkg::COLOR_W
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               START,
    input  logic [4:0]         SIZE,
    input  logic [7:0]         MOVES,
    input  logic [7:0]         MOVE_LIMIT,
    output logic [4:0]         RD_ROW,
    output logic [4:0]         RD_COL,
    input  logic [COLOR_W-1:0] RD_DATA,
    output logic               BUSY,
    output logic               DONE,
    output logic               WIN,
    output logic               LOSE,
    output logic [9:0]         FLOOD_COUNT
);

    import floodit_pkg::*;

    checker_state_e state_q, state_d;

    logic [ADDR_W-1:0]  size_q;
    logic [MOVES_W-1:0] moves_q;
    logic [MOVES_W-1:0] limit_q;

    // Address issue stage and the one-cycle-later data stage
    logic issue_q;
    logic rd_valid_q;
    logic rd_first_q;
    logic rd_last_q;

    logic [COLOR_W-1:0] ref_q;
    logic               all_match_q;
    logic               win_q;
    logic               lose_q;

    logic [ADDR_W-1:0] scan_row;
    logic [ADDR_W-1:0] scan_col;
    logic              scan_last;

    logic start_acc;
    logic issuing;
    logic consume;
    logic cell_match;
    logic cell_abort;
    logic match_all_d;
    logic enter_finish;
    logic win_d;
    logic lose_d;

    assign start_acc  = (state_q == StIdle) && START;
    assign issuing    = (state_q == StScan) && issue_q;
    assign consume    = (state_q == StScan) && rd_valid_q;
    // Cell (0,0) is the reference, so it always matches itself
    assign cell_match = rd_first_q || (RD_DATA == ref_q);
    assign match_all_d = all_match_q && (!consume || cell_match);

    cell_scan_counter #(
        .AddrW (ADDR_W)
    ) u_scan (
        .clk_i     (CLOCK),
        .rst_ni    (RESET_N),
        .clear_i   (start_acc),
        .advance_i (issuing && !scan_last),
        .size_i    (size_q),
        .row_o     (scan_row),
        .col_o     (scan_col),
        .last_o    (scan_last)
    );

`ifdef CHECKER_PROGRESS_EN
    logic [COUNT_W-1:0] count_q;

    assign cell_abort  = 1'b0;
    assign FLOOD_COUNT = count_q;

    // Matching-cell counter, saturating
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            count_q <= '0;
        end else if (start_acc) begin
            count_q <= '0;
        end else if (consume && cell_match && (count_q != COUNT_MAX)) begin
            count_q <= count_q + 10'd1;
        end
    end
`else
    assign cell_abort  = !cell_match;
    assign FLOOD_COUNT = '0;
`endif

    // Next state: SCAN ends on the last consumed cell, an early abort or an empty board
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (START) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                if (size_q == '0) begin
                    state_d = StFinish;
                end else if (rd_valid_q && (rd_last_q || cell_abort)) begin
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign enter_finish = (state_q == StScan) && (state_d == StFinish);
    assign win_d  = (size_q != '0) && match_all_d;
    assign lose_d = !win_d && (size_q != '0) && (limit_q != '0) && (moves_q >= limit_q);

    // State register
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request parameters captured on an accepted START
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            size_q  <= '0;
            moves_q <= '0;
            limit_q <= '0;
        end else if (start_acc) begin
            size_q  <= clamp_size(SIZE, MAX_SIZE);
            moves_q <= MOVES;
            limit_q <= MOVE_LIMIT;
        end
    end

    // Address issue and read-data pipeline tracking
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            issue_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_first_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            if (start_acc) begin
                issue_q <= (clamp_size(SIZE, MAX_SIZE) != '0);
            end else if (enter_finish || (issuing && scan_last)) begin
                issue_q <= 1'b0;
            end
            rd_valid_q <= issuing && !enter_finish;
            rd_first_q <= issuing && !enter_finish && (scan_row == '0) && (scan_col == '0);
            rd_last_q  <= issuing && !enter_finish && scan_last;
        end
    end

    // Reference colour, running all-match flag and the held result flags
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            ref_q       <= '0;
            all_match_q <= 1'b1;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
        end else begin
            if (consume && rd_first_q) begin
                ref_q <= RD_DATA;
            end
            if (start_acc) begin
                all_match_q <= 1'b1;
            end else if (consume) begin
                all_match_q <= match_all_d;
            end
            if (start_acc) begin
                win_q  <= 1'b0;
                lose_q <= 1'b0;
            end else if (enter_finish) begin
                win_q  <= win_d;
                lose_q <= lose_d;
            end
        end
    end

    assign BUSY   = (state_q != StIdle);
    assign DONE   = (state_q == StFinish);
    assign WIN    = win_q;
    assign LOSE   = lose_q;
    assign RD_ROW = (state_q == StScan) ? scan_row : '0;
    assign RD_COL = (state_q == StScan) ? scan_col : '0;

endmodule
